// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the execute/load write-back sources, decode issue logic
// and the register-file write port managed by rf_wb_arbiter.
interface rf_wb_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              issue_ready;

    logic              alu_valid;
    logic [AW-1:0]     alu_rd;
    logic [DW-1:0]     alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [AW-1:0]     mem_rd;
    logic [DW-1:0]     mem_data;
    logic              mem_ready;

    logic              rf_wen;
    logic [AW-1:0]     rf_rd;
    logic [DW-1:0]     rf_din;

    logic [2**AW-1:0]  busy;
    logic              err_underflow;

    // Requesters and decode sit on the master side; the arbiter is the slave.
    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  issue_ready, alu_ready, mem_ready,
        input  rf_wen, rf_rd, rf_din, busy, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output issue_ready, alu_ready, mem_ready,
        output rf_wen, rf_rd, rf_din, busy, err_underflow
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs load) for the register-file write port,
// plus a per-register pending-write scoreboard used for RAW/WAW hazard detection.
module rf_wb_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int CW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int NR = 2**AW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {PTR_ALU, PTR_MEM} ptr_t;

    ptr_t           ptr;
    logic [CW-1:0]  cnt [NR];
    logic           grant_alu;
    logic           grant_mem;
    logic           wen_q;
    logic [AW-1:0]  rd_q;
    logic [DW-1:0]  din_q;
    logic           err_q;
    logic [NR-1:0]  inc;
    logic [NR-1:0]  dec;
    logic [NR-1:0]  busy_vec;

    // The pointer only breaks ties; a lone valid is always granted.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (rst_n) begin
            if (bus.alu_valid && bus.mem_valid) begin
                grant_alu = (ptr == PTR_ALU);
                grant_mem = (ptr == PTR_MEM);
            end else begin
                grant_alu = bus.alu_valid;
                grant_mem = bus.mem_valid;
            end
        end
    end

    assign bus.alu_ready   = grant_alu;
    assign bus.mem_ready   = grant_mem;
    assign bus.issue_ready = rst_n && (cnt[bus.issue_rd] != CNT_MAX);

    always_comb begin
        inc      = '0;
        dec      = '0;
        busy_vec = '0;
        for (int i = 0; i < NR; i++) begin
            inc[i]      = bus.issue_valid && bus.issue_ready && (bus.issue_rd == AW'(i));
            dec[i]      = wen_q && (rd_q == AW'(i));
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= PTR_ALU;
            wen_q <= 1'b0;
            rd_q  <= '0;
            din_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (grant_alu) begin
                wen_q <= 1'b1;
                rd_q  <= bus.alu_rd;
                din_q <= bus.alu_data;
                ptr   <= PTR_MEM;
            end else if (grant_mem) begin
                wen_q <= 1'b1;
                rd_q  <= bus.mem_rd;
                din_q <= bus.mem_data;
                ptr   <= PTR_ALU;
            end else begin
                wen_q <= 1'b0;
            end

            // A write with nothing pending is flagged but never wraps the counter.
            for (int i = 0; i < NR; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rf_wen        = wen_q;
    assign bus.rf_rd         = rd_q;
    assign bus.rf_din        = din_q;
    assign bus.busy          = busy_vec;
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: reset, latency, round-robin,
// counter saturation, underflow flag and mid-operation reset.
module tb_rf_wb_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rf_wb_arbiter_if #(.DW(8), .AW(3)) bus ();

    rf_wb_arbiter #(.DW(8), .AW(3), .CW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;

        // Reset, with requests asserted while rst_n is low
        applyStimulus();
        applyStimulus();
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_data = 8'hEE;
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd2;
        settle();
        checkOutput("rst_alu_ready", bus.alu_ready, 1'b0);
        checkOutput("rst_issue_ready", bus.issue_ready, 1'b0);
        applyStimulus();
        checkOutput("rst_rf_wen", bus.rf_wen, 1'b0);
        bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
        rst_n = 1'b1;
        settle();
        checkOutput("idle_rf_wen", bus.rf_wen, 1'b0);
        checkOutput("idle_busy", bus.busy, 8'h00);
        checkOutput("idle_err", bus.err_underflow, 1'b0);
        checkOutput("idle_issue_ready", bus.issue_ready, 1'b1);
        checkOutput("idle_rf_rd", bus.rf_rd, 3'd0);
        checkOutput("idle_rf_din", bus.rf_din, 8'h00);

        // Issue r3, write it two cycles later
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd3;
        applyStimulus();
        bus.issue_valid = 1'b0;
        settle();
        checkOutput("r3_busy_c1", bus.busy, 8'h08);
        applyStimulus();
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 8'hA5;
        settle();
        checkOutput("r3_alu_ready", bus.alu_ready, 1'b1);
        checkOutput("r3_busy_c2", bus.busy, 8'h08);
        applyStimulus();
        bus.alu_valid = 1'b0;
        settle();
        checkOutput("r3_rf_wen", bus.rf_wen, 1'b1);
        checkOutput("r3_rf_rd", bus.rf_rd, 3'd3);
        checkOutput("r3_rf_din", bus.rf_din, 8'hA5);
        checkOutput("r3_busy_c3", bus.busy, 8'h08);
        applyStimulus();
        checkOutput("r3_busy_c4", bus.busy, 8'h00);
        checkOutput("r3_wen_off", bus.rf_wen, 1'b0);
        checkOutput("r3_din_hold", bus.rf_din, 8'hA5);

        // Load write to r6 with nothing pending (pointer favours MEM now)
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd6; bus.mem_data = 8'h66;
        settle();
        checkOutput("r6_mem_ready", bus.mem_ready, 1'b1);
        checkOutput("r6_alu_ready", bus.alu_ready, 1'b0);
        applyStimulus();
        bus.mem_valid = 1'b0;
        settle();
        checkOutput("r6_rf_wen", bus.rf_wen, 1'b1);
        checkOutput("r6_rf_rd", bus.rf_rd, 3'd6);
        checkOutput("r6_err_before", bus.err_underflow, 1'b0);
        applyStimulus();
        checkOutput("r6_err_set", bus.err_underflow, 1'b1);
        checkOutput("r6_busy", bus.busy, 8'h00);
        applyStimulus();
        checkOutput("r6_err_sticky", bus.err_underflow, 1'b1);

        // Round-robin: two pending writes each on r1 and r2, both sources held
        bus.issue_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.issue_rd = (k % 2 == 0) ? 3'd1 : 3'd2;
            applyStimulus();
        end
        bus.issue_valid = 1'b0;
        settle();
        checkOutput("rr_busy_pre", bus.busy, 8'h06);
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 8'h11;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 8'h22;
        settle();
        checkOutput("rr_g0_alu", bus.alu_ready, 1'b1);
        checkOutput("rr_g0_mem", bus.mem_ready, 1'b0);
        applyStimulus();
        settle();
        checkOutput("rr_g1_mem", bus.mem_ready, 1'b1);
        checkOutput("rr_g1_alu", bus.alu_ready, 1'b0);
        checkOutput("rr_din0", bus.rf_din, 8'h11);
        applyStimulus();
        settle();
        checkOutput("rr_g2_alu", bus.alu_ready, 1'b1);
        checkOutput("rr_din1", bus.rf_din, 8'h22);
        checkOutput("rr_rd1", bus.rf_rd, 3'd2);
        applyStimulus();
        settle();
        checkOutput("rr_g3_mem", bus.mem_ready, 1'b1);
        checkOutput("rr_din2", bus.rf_din, 8'h11);
        applyStimulus();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        settle();
        checkOutput("rr_din3", bus.rf_din, 8'h22);
        checkOutput("rr_wen3", bus.rf_wen, 1'b1);
        checkOutput("rr_busy_r2", bus.busy, 8'h04);
        applyStimulus();
        checkOutput("rr_wen_off", bus.rf_wen, 1'b0);
        checkOutput("rr_busy_done", bus.busy, 8'h00);

        // Saturate r5, then drain while issuing
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd5;
        for (int k = 0; k < 3; k++) begin
            settle();
            checkOutput("sat_issue_ready", bus.issue_ready, 1'b1);
            applyStimulus();
        end
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_data = 8'h55;
        settle();
        checkOutput("sat_full", bus.issue_ready, 1'b0);
        checkOutput("sat_busy", bus.busy, 8'h20);
        checkOutput("sat_alu_ready", bus.alu_ready, 1'b1);
        applyStimulus();
        bus.issue_valid = 1'b0;
        bus.alu_data = 8'h56;
        settle();
        checkOutput("sat_still_full", bus.issue_ready, 1'b0);
        checkOutput("sat_w1_rd", bus.rf_rd, 3'd5);
        checkOutput("sat_w1_din", bus.rf_din, 8'h55);
        applyStimulus();
        bus.alu_valid = 1'b0;
        settle();
        checkOutput("sat_cnt2_ready", bus.issue_ready, 1'b1);
        checkOutput("sat_w2_din", bus.rf_din, 8'h56);
        applyStimulus();
        checkOutput("sat_cnt1_busy", bus.busy, 8'h20);
        checkOutput("sat_cnt1_wen", bus.rf_wen, 1'b0);
        // Issue and write back on the same edge: count stays 1
        bus.alu_valid = 1'b1; bus.alu_data = 8'h57;
        applyStimulus();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd5;
        settle();
        checkOutput("both_wen", bus.rf_wen, 1'b1);
        checkOutput("both_issue_ready", bus.issue_ready, 1'b1);
        applyStimulus();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_data = 8'h58;
        applyStimulus();
        bus.alu_valid = 1'b0;
        settle();
        checkOutput("both_busy_hold", bus.busy, 8'h20);
        applyStimulus();
        checkOutput("both_busy_clear", bus.busy, 8'h00);
        checkOutput("both_err_sticky", bus.err_underflow, 1'b1);

        // Reset right after an ALU grant (pointer currently favours MEM)
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd4;
        applyStimulus();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd4; bus.alu_data = 8'h7E;
        applyStimulus();
        bus.alu_valid = 1'b0;
        rst_n = 1'b0;
        settle();
        checkOutput("mr_wen_pre", bus.rf_wen, 1'b1);
        checkOutput("mr_busy_pre", bus.busy, 8'h10);
        applyStimulus();
        checkOutput("mr_wen", bus.rf_wen, 1'b0);
        checkOutput("mr_busy", bus.busy, 8'h00);
        checkOutput("mr_err", bus.err_underflow, 1'b0);
        rst_n = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 8'h01;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd7; bus.mem_data = 8'h02;
        settle();
        checkOutput("mr_ptr_alu", bus.alu_ready, 1'b1);
        checkOutput("mr_ptr_mem", bus.mem_ready, 1'b0);
        applyStimulus();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        settle();
        checkOutput("mr_first_din", bus.rf_din, 8'h01);
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
